vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator; successor to the fixed 640x480 counter/sync block in the display path.
- Generalises the timing values, sync polarity and pixel-clock divide ratio.
- Adds data-enable, pixel coordinates, line/frame strobes, and registered, aligned RGB outputs.
- Sits between the system clock and the VGA pins; the Game of Life frame renderer drives pixel colour from x/y.

---
 rtl/vga_timing_gen.sv | 171 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-clock divider and registered syncs/colour.
// Define VGA_TIMING_TESTPAT_EN to replace r_in/g_in/b_in with bordered 8-bar colour test pattern.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 4,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [3:0]    r_in,
  input  logic [3:0]    g_in,
  input  logic [3:0]    b_in,
  output logic          pix_ce,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          de,
  output logic          line_start,
  output logic          frame_start,
  output logic          hsync_vga,
  output logic          vsync_vga,
  output logic [3:0]    r_vga,
  output logic [3:0]    g_vga,
  output logic [3:0]    b_vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SYN_LO = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYN_HI = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYN_LO = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYN_HI = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  function automatic logic sync_level(input logic [CW-1:0] cnt, input logic [CW-1:0] lo,
                                      input logic [CW-1:0] hi, input logic pol);
    return ((cnt >= lo) && (cnt < hi)) ? pol : ~pol;
  endfunction

  // ---- divider: pixel strobe ----
  if (CLK_DIV > 1) begin : g_div
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    logic [DW-1:0] div;

    always_ff @(posedge clk) begin
      if (rst)
        div <= '0;
      else if (en)
        div <= (div == DIV_LAST) ? '0 : div + DW'(1);
    end

    assign pix_ce = en & (div == DIV_LAST);
  end else begin : g_nodiv
    assign pix_ce = en;
  end

  // ---- stage p0: raster counters and decoded pixel state ----
  logic [CW-1:0] h_cnt, v_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end
  end

  logic          de_p0, hs_p0, vs_p0, ls_p0, fs_p0;
  logic [CW-1:0] x_p0, y_p0;
  logic [3:0]    r_p0, g_p0, b_p0;

`ifdef VGA_TIMING_TESTPAT_EN
  localparam logic [CW+2:0] H_ACT_X = (CW+3)'(H_ACTIVE);
  logic [2:0] bar_idx;
  logic       border;
  logic       unused_in;

  assign bar_idx   = 3'({h_cnt, 3'b000} / H_ACT_X);
  assign border    = (h_cnt == '0) || (h_cnt == H_ACT_C - CW'(1)) ||
                     (v_cnt == '0) || (v_cnt == V_ACT_C - CW'(1));
  assign unused_in = ^{r_in, g_in, b_in};
`endif

  always_comb begin
    de_p0 = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    x_p0  = de_p0 ? h_cnt : '0;
    y_p0  = de_p0 ? v_cnt : '0;
    hs_p0 = sync_level(h_cnt, H_SYN_LO, H_SYN_HI, HS_POL);
    vs_p0 = sync_level(v_cnt, V_SYN_LO, V_SYN_HI, VS_POL);
    ls_p0 = de_p0 && (h_cnt == '0);
    fs_p0 = ls_p0 && (v_cnt == '0);
    r_p0  = '0;
    g_p0  = '0;
    b_p0  = '0;
    if (de_p0) begin
`ifdef VGA_TIMING_TESTPAT_EN
      // Bar colour bits are the inverted index bits: white, yellow, cyan, ... black.
      r_p0 = (border || !bar_idx[1]) ? 4'hF : 4'h0;
      g_p0 = (border || !bar_idx[2]) ? 4'hF : 4'h0;
      b_p0 = (border || !bar_idx[0]) ? 4'hF : 4'h0;
`else
      r_p0 = r_in;
      g_p0 = g_in;
      b_p0 = b_in;
`endif
    end
  end

  // ---- stage p1: registered outputs, updated once per pixel ----
  logic          de_p1, hs_p1, vs_p1, ls_p1, fs_p1;
  logic [CW-1:0] x_p1, y_p1;
  logic [3:0]    r_p1, g_p1, b_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      de_p1 <= 1'b0;
      x_p1  <= '0;
      y_p1  <= '0;
      ls_p1 <= 1'b0;
      fs_p1 <= 1'b0;
      hs_p1 <= ~HS_POL;
      vs_p1 <= ~VS_POL;
      r_p1  <= '0;
      g_p1  <= '0;
      b_p1  <= '0;
    end else if (pix_ce) begin
      de_p1 <= de_p0;
      x_p1  <= x_p0;
      y_p1  <= y_p0;
      ls_p1 <= ls_p0;
      fs_p1 <= fs_p0;
      hs_p1 <= hs_p0;
      vs_p1 <= vs_p0;
      r_p1  <= r_p0;
      g_p1  <= g_p0;
      b_p1  <= b_p0;
    end
  end

  assign de          = de_p1;
  assign x           = x_p1;
  assign y           = y_p1;
  assign line_start  = ls_p1;
  assign frame_start = fs_p1;
  assign hsync_vga   = hs_p1;
  assign vsync_vga   = vs_p1;
  assign r_vga       = r_p1;
  assign g_vga       = g_p1;
  assign b_vga       = b_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a tiny 8x5 raster (4x2 active), CLK_DIV=2, HS_POL=1.
module tb_vga_timing_gen;

  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst, en;
  logic [3:0]    r_in, g_in, b_in;
  logic          pix_ce;
  logic [CW-1:0] x, y;
  logic          de, line_start, frame_start, hsync_vga, vsync_vga;
  logic [3:0]    r_vga, g_vga, b_vga;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(2), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .pix_ce(pix_ce), .x(x), .y(y), .de(de),
    .line_start(line_start), .frame_start(frame_start),
    .hsync_vga(hsync_vga), .vsync_vga(vsync_vga),
    .r_vga(r_vga), .g_vga(g_vga), .b_vga(b_vga)
  );

  int total = 0;
  int bad   = 0;

  // Hand-derived per-column / per-row expectations for the 8x5 raster.
  int xtab  [8] = '{0, 1, 2, 3, 0, 0, 0, 0};
  int deh   [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  int hstab [8] = '{0, 0, 0, 0, 0, 1, 1, 0};
  int dev   [5] = '{1, 1, 0, 0, 0};
  int vstab [5] = '{1, 1, 1, 0, 1};

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_reset();
    chk("rst_de", de, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_ls", line_start, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_hs", hsync_vga, 0);
    chk("rst_vs", vsync_vga, 1);
    chk("rst_r", r_vga, 0);
    chk("rst_g", g_vga, 0);
    chk("rst_b", b_vga, 0);
  endtask

  task automatic check_pixel(input int h, input int v);
    int e_de, e_ls;
    e_de = deh[h] & dev[v];
    e_ls = e_de & ((h == 0) ? 1 : 0);
    chk("de", de, e_de);
    chk("x", x, e_de ? xtab[h] : 0);
    chk("y", y, e_de ? v : 0);
    chk("line_start", line_start, e_ls);
    chk("frame_start", frame_start, e_ls & ((v == 0) ? 1 : 0));
    chk("hsync", hsync_vga, hstab[h]);
    chk("vsync", vsync_vga, vstab[v]);
`ifdef VGA_TIMING_TESTPAT_EN
    chk("r", r_vga, e_de ? 15 : 0);
    chk("g", g_vga, e_de ? 15 : 0);
    chk("b", b_vga, e_de ? 15 : 0);
`else
    chk("r", r_vga, e_de ? ((h + 1) & 15) : 0);
    chk("g", g_vga, e_de ? ((v + 5) & 15) : 0);
    chk("b", b_vga, e_de ? 10 : 0);
`endif
  endtask

  // Entered at a falling edge where the divider is at 0; exits the same way.
  task automatic run_pixels(input int n, input int freeze_at);
    for (int k = 0; k < n; k++) begin
      if (k > 0) check_pixel((k - 1) % 8, ((k - 1) / 8) % 5);
      chk("pix_ce_lo", pix_ce, 0);
      r_in = 4'((k % 8) + 1);
      g_in = 4'(((k / 8) % 5) + 5);
      b_in = 4'hA;
      @(negedge clk);
      chk("pix_ce_hi", pix_ce, 1);
      if (k == freeze_at) begin
        en = 1'b0;
        #1;
        chk("frz_ce", pix_ce, 0);
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("frz_ce", pix_ce, 0);
          check_pixel((k - 1) % 8, ((k - 1) / 8) % 5);
        end
        en = 1'b1;
        #1;
        chk("resume_ce", pix_ce, 1);
      end
      @(negedge clk);
    end
    check_pixel((n - 1) % 8, ((n - 1) / 8) % 5);
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    r_in = '0;
    g_in = '0;
    b_in = '0;
    repeat (3) @(negedge clk);
    check_reset();
    chk("rst_ce", pix_ce, 0);
    rst = 1'b0;
    en  = 1'b1;

    // Two full frames plus a few pixels, with an en gap mid-line.
    run_pixels(85, 13);

    // Reset mid-line: state returns to reset values, then restarts at (0,0).
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset();
    chk("rst2_ce", pix_ce, 0);
    rst = 1'b0;
    run_pixels(3, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
